// File: rtl/i2c_sched_pkg.sv
// Shared types and field positions for the I2C transaction scheduler.
package i2c_sched_pkg;

   // Scheduler states; the encoding is exported on the debug state port.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_RESP      = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

   // Response status codes.
   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_NACK    = 2'b01,
      ERR_TIMEOUT = 2'b10,
      ERR_BADCMD  = 2'b11
   } err_t;

   // Command word layout.
   localparam int CMD_SLV_MSB  = 31;
   localparam int CMD_SLV_LSB  = 24;
   localparam int CMD_REG_MSB  = 23;
   localparam int CMD_REG_LSB  = 16;
   localparam int CMD_WDAT_MSB = 15;
   localparam int CMD_WDAT_LSB = 8;
   localparam int CMD_BC_MSB   = 1;
   localparam int CMD_BC_LSB   = 0;
   localparam int CMD_RW_BIT   = 24;   // 1 = read

   // Response record returned to the granted requester.
   typedef struct packed {
      logic       id;
      err_t       err;
      logic [7:0] rdata;
   } rsp_t;

   // Only one- and two-byte transfers are supported by the engine.
   function automatic logic bc_legal(input logic [1:0] bc);
      return (bc == 2'd1) || (bc == 2'd2);
   endfunction

endpackage

// File: rtl/i2c_txn_scheduler_arb.sv
// Two-port round-robin arbiter; the last-grant register flips priority
// only when the caller actually consumes the winner (advance).
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       win_valid,
   output logic       win_id
);

   // last_q = 1 after reset so port 0 is favoured on the first contention.
   logic last_q, last_d;

   // Winner: lone requester, or the port not granted last when both ask.
   always_comb begin
      win_valid = |req;
      if (req == 2'b11) win_id = ~last_q;
      else              win_id = req[1];
      last_d = advance ? win_id : last_q;
   end

   // Last-grant register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_q <= 1'b1;
      else          last_q <= last_d;
   end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Shares one I2C master engine between the host command path (port 0)
// and the sensor poller (port 1): round-robin grant, timeout supervision,
// bus-free gap, and status/read-data return to the granted port.
module i2c_txn_scheduler
   import i2c_sched_pkg::*;
#(
   parameter int CMD_W       = 32,
   parameter int TIMEOUT_CYC = 200000,   // must be >= 2
   parameter int GAP_CYC     = 100       // 1 .. 65535
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0,
   input  logic [CMD_W-1:0] cmd0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [CMD_W-1:0] cmd1,
   output logic             gnt1,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [1:0]       rsp_err,
   output logic [7:0]       rsp_rdata,
   output logic [CMD_W-1:0] eng_cmd,
   output logic             eng_start,
   output logic             eng_abort,
   input  logic             eng_done,
   input  logic             eng_nack,
   input  logic [7:0]       eng_rdata,
   output logic             busy,
   output logic [2:0]       state
);

   localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   // Timeout fires on the edge where the counter steps to TIMEOUT_CYC-1,
   // so eng_abort lands exactly TIMEOUT_CYC cycles after eng_start.
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 2);
   // The IDLE sampling cycle is the last of the GAP_CYC quiet cycles,
   // so the GAP state itself lasts GAP_CYC-1 cycles.
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   rsp_t             rsp_q, rsp_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             start_q, start_d, abort_q, abort_d;
   logic             rsp_valid_q, rsp_valid_d, busy_q, busy_d;

   logic             win_valid, win_id, arb_adv;
   logic [CMD_W-1:0] win_cmd;
   logic             win_ok, cmd_ok;

   rr_arb2 u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       ({req1, req0}),
      .advance   (arb_adv),
      .win_valid (win_valid),
      .win_id    (win_id)
   );

   assign arb_adv = (state_q == ST_IDLE) && win_valid;
   assign win_cmd = win_id ? cmd1 : cmd0;
   assign win_ok  = bc_legal(win_cmd[CMD_BC_MSB:CMD_BC_LSB]);
   assign cmd_ok  = bc_legal(cmd_q[CMD_BC_MSB:CMD_BC_LSB]);

   // Next-state and registered-output logic for the transaction FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      rsp_d       = rsp_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      start_d     = 1'b0;
      abort_d     = 1'b0;
      rsp_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d  = ST_ISSUE;
               cmd_d    = win_cmd;
               rsp_d.id = win_id;
               gnt0_d   = ~win_id;
               gnt1_d   = win_id;
               start_d  = win_ok;
            end
         end
         ST_ISSUE: begin
            if (cmd_ok) begin
               state_d = ST_WAIT_DONE;
               cnt_d   = '0;
            end else begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_d.err   = ERR_BADCMD;
               rsp_d.rdata = 8'h00;
            end
         end
         ST_WAIT_DONE: begin
            cnt_d = cnt_q + 1'b1;
            if (eng_done) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_d.err   = eng_nack ? ERR_NACK : ERR_OK;
               rsp_d.rdata = (!eng_nack && cmd_q[CMD_RW_BIT]) ? eng_rdata : 8'h00;
            end else if (cnt_q == TO_LAST) begin
               state_d     = ST_RESP;
               abort_d     = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_d.err   = ERR_TIMEOUT;
               rsp_d.rdata = 8'h00;
            end
         end
         ST_RESP: begin
            if (GAP_CYC > 1) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         rsp_q       <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         start_q     <= 1'b0;
         abort_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         rsp_q       <= rsp_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         start_q     <= start_d;
         abort_q     <= abort_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign eng_start = start_q;
   assign eng_abort = abort_q;
   assign eng_cmd   = cmd_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_q.id;
   assign rsp_err   = rsp_q.err;
   assign rsp_rdata = rsp_q.rdata;
   assign busy      = busy_q;
   assign state     = state_q;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Bench for i2c_txn_scheduler: vector table, hand-written corner sequences
// and random transactions checked against a rule-level reference model.
module tb_i2c_txn_scheduler;

   localparam int TO  = 50;
   localparam int GAP = 5;

   logic        clk, reset_n;
   logic        req0, req1, gnt0, gnt1;
   logic [31:0] cmd0, cmd1, eng_cmd;
   logic        rsp_valid, rsp_id, eng_start, eng_abort;
   logic [1:0]  rsp_err;
   logic [7:0]  rsp_rdata, eng_rdata;
   logic        eng_done, eng_nack, busy;
   logic [2:0]  state;

   int n_chk  = 0;
   int n_fail = 0;

   i2c_txn_scheduler #(.CMD_W(32), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .cmd0(cmd0), .gnt0(gnt0),
      .req1(req1), .cmd1(cmd1), .gnt1(gnt1),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .eng_cmd(eng_cmd), .eng_start(eng_start), .eng_abort(eng_abort),
      .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata),
      .busy(busy), .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Reference timing, in cycles after the grant/eng_start cycle.
   // Legal byte count: done in 1..TO-1 answers at done+1, anything else
   // times out with abort and response TO cycles after start.
   function automatic void ref_timing(input logic [31:0] cmd, input int dly,
                                      output bit start, output int rsp_k, output bit abort);
      logic [1:0] bc;
      bc    = cmd[1:0];
      start = (bc == 2'd1) || (bc == 2'd2);
      abort = 1'b0;
      if (!start)                    rsp_k = 1;
      else if (dly >= 1 && dly < TO) rsp_k = dly + 1;
      else begin rsp_k = TO; abort = 1'b1; end
   endfunction

   // Reference status and read data.
   function automatic void ref_result(input logic [31:0] cmd, input int dly, input bit nack,
                                      input logic [7:0] rd, output logic [1:0] err, output logic [7:0] xrd);
      bit start, abort;
      int rsp_k;
      ref_timing(cmd, dly, start, rsp_k, abort);
      xrd = 8'h00;
      if (!start)     err = 2'b11;
      else if (abort) err = 2'b10;
      else begin
         err = nack ? 2'b01 : 2'b00;
         if (!nack && cmd[24]) xrd = rd;
      end
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while (state !== 3'd0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (state !== 3'd0) chk("wait_idle.timeout", 32'(state), 32'd0);
   endtask

   // One transaction from a single port; engine answers dly cycles after
   // eng_start (0 = never). Always returns on a falling edge.
   task automatic do_txn(input string nm, input bit port, input logic [31:0] cmd, input int dly,
                         input bit nack, input logic [7:0] rd,
                         input logic [1:0] xerr, input logic [7:0] xrd);
      bit         start, abort;
      int         rsp_k, kmax, nrsp, rsp_at, nab, ab_at;
      logic [1:0] gerr;
      logic [7:0] grd;
      logic       gid;
      ref_timing(cmd, dly, start, rsp_k, abort);
      wait_idle();
      if (port) begin req1 = 1'b1; cmd1 = cmd; end
      else      begin req0 = 1'b1; cmd0 = cmd; end
      @(negedge clk);
      chk({nm, ".gnt"},     32'({gnt1, gnt0}), port ? 32'd2 : 32'd1);
      chk({nm, ".start"},   32'(eng_start), 32'(start));
      chk({nm, ".eng_cmd"}, eng_cmd, cmd);
      chk({nm, ".issue"},   32'({busy, state}), 32'h9);
      req0 = 1'b0; req1 = 1'b0;
      nrsp = 0; rsp_at = -1; nab = 0; ab_at = -1;
      gerr = 2'b00; grd = 8'h00; gid = 1'b0;
      kmax = ((rsp_k > dly) ? rsp_k : dly) + 2;
      for (int k = 1; k <= kmax; k++) begin
         @(negedge clk);
         eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
         if (rsp_valid) begin
            nrsp++; rsp_at = k; gerr = rsp_err; grd = rsp_rdata; gid = rsp_id;
         end
         if (eng_abort) begin nab++; ab_at = k; end
         if (k == dly) begin eng_done = 1'b1; eng_nack = nack; eng_rdata = rd; end
      end
      eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
      chk({nm, ".rsp_count"}, 32'(nrsp), 32'd1);
      chk({nm, ".rsp_cycle"}, 32'(rsp_at), 32'(rsp_k));
      chk({nm, ".rsp_err"},   32'(gerr), 32'(xerr));
      chk({nm, ".rsp_rdata"}, 32'(grd), 32'(xrd));
      chk({nm, ".rsp_id"},    32'(gid), 32'(port));
      chk({nm, ".abort_cnt"}, 32'(nab), 32'(abort));
      if (abort) chk({nm, ".abort_cycle"}, 32'(ab_at), 32'(TO));
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      bit          port;
      logic [31:0] cmd;
      int          dly;
      bit          nack;
      logic [7:0]  rd;
      logic [1:0]  xerr;
      logic [7:0]  xrd;
   } vec_t;

   vec_t tbl [10];

   initial begin
      bit          seen, p, nk;
      logic [31:0] c;
      int          d, ng, nr, last_g, done_at, exp_port;
      logic [7:0]  r, x;
      logic [1:0]  e;
      int          gq[$];

      tbl[0] = '{1'b0, 32'h32283301, 10, 1'b0, 8'h5A, 2'b00, 8'h00}; // write ok
      tbl[1] = '{1'b1, 32'h33290001,  4, 1'b0, 8'hA5, 2'b00, 8'hA5}; // read ok
      tbl[2] = '{1'b0, 32'h32280000,  0, 1'b0, 8'h00, 2'b11, 8'h00}; // bc 0
      tbl[3] = '{1'b1, 32'h33290003,  0, 1'b0, 8'h00, 2'b11, 8'h00}; // bc 3
      tbl[4] = '{1'b0, 32'h33290002,  7, 1'b1, 8'h77, 2'b01, 8'h00}; // read nack
      tbl[5] = '{1'b1, 32'h32283302,  2, 1'b1, 8'h11, 2'b01, 8'h00}; // write nack
      tbl[6] = '{1'b0, 32'h33290001, 49, 1'b0, 8'h3C, 2'b00, 8'h3C}; // done on timeout edge
      tbl[7] = '{1'b1, 32'h33290001,  0, 1'b0, 8'h00, 2'b10, 8'h00}; // never done
      tbl[8] = '{1'b0, 32'h332900FD,  1, 1'b0, 8'hC3, 2'b00, 8'hC3}; // reserved bits set
      tbl[9] = '{1'b1, 32'h32280002, 50, 1'b0, 8'h99, 2'b10, 8'h00}; // done one cycle late

      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0;
      eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
      #2;
      chk("reset.outs", 32'({gnt0, gnt1, rsp_valid, rsp_id, rsp_err, rsp_rdata,
                             eng_start, eng_abort, busy, state}), 32'd0);
      chk("reset.eng_cmd", eng_cmd, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset.idle", 32'({busy, state}), 32'd0);

      for (int i = 0; i < 10; i++)
         do_txn($sformatf("vec%0d", i), tbl[i].port, tbl[i].cmd, tbl[i].dly,
                tbl[i].nack, tbl[i].rd, tbl[i].xerr, tbl[i].xrd);

      // Timeout, then a stray done and a short request during the gap.
      do_txn("timeout", 1'b1, 32'h32280002, 0, 1'b0, 8'h00, 2'b10, 8'h00);
      chk("gap.state", 32'(state), 32'd4);
      eng_done = 1'b1; req1 = 1'b1; cmd1 = 32'h33290001;
      @(negedge clk);
      eng_done = 1'b0; req1 = 1'b0;
      seen = 1'b0;
      repeat (GAP + 4) begin
         @(negedge clk);
         seen = seen | gnt0 | gnt1 | rsp_valid | eng_start;
      end
      chk("gap.ignored", 32'(seen), 32'd0);
      chk("gap.idle", 32'(state), 32'd0);
      chk("hold.rsp_id", 32'(rsp_id), 32'd1);
      chk("hold.eng_cmd", eng_cmd, 32'h32280002);

      for (int i = 0; i < 30; i++) begin
         p  = 1'($urandom_range(0, 1));
         c  = $urandom();
         d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO + 6));
         nk = ($urandom_range(0, 3) == 0);
         r  = 8'($urandom_range(0, 255));
         ref_result(c, d, nk, r, e, x);
         do_txn($sformatf("rnd%0d", i), p, c, d, nk, r, e, x);
      end

      // Both ports held: grants alternate from port 0; with the engine
      // answering 3 cycles after start, next grant = done + 2 + GAP.
      wait_idle();
      apply_reset();
      req0 = 1'b1; req1 = 1'b1; cmd0 = 32'h32283301; cmd1 = 32'h33290002;
      ng = 0; nr = 0; last_g = -1; done_at = -1; exp_port = 0;
      for (int cy = 0; cy < 300 && nr < 4; cy++) begin
         @(negedge clk);
         eng_done = 1'b0;
         if (rsp_valid) begin
            if (gq.size() > 0) chk("alt.rsp_id", 32'(rsp_id), 32'(gq.pop_front()));
            nr++;
         end
         if (gnt0 || gnt1) begin
            chk("alt.gnt", 32'({gnt1, gnt0}), exp_port ? 32'd2 : 32'd1);
            gq.push_back(exp_port);
            if (last_g >= 0) chk("alt.spacing", 32'(cy - last_g), 32'(GAP + 5));
            last_g = cy; done_at = cy + 3; exp_port = 1 - exp_port; ng++;
            if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
         end
         if (cy == done_at) eng_done = 1'b1;
      end
      eng_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
      chk("alt.grants", 32'(ng), 32'd4);
      chk("alt.responses", 32'(nr), 32'd4);

      // Reset during WAIT_DONE, then normal service.
      wait_idle();
      req0 = 1'b1; cmd0 = 32'h33290001;
      @(negedge clk);
      chk("rst.gnt", 32'({gnt1, gnt0}), 32'd1);
      req0 = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst.wait_state", 32'(state), 32'd2);
      #2 reset_n = 1'b0;
      #1;
      chk("rst.outs", 32'({gnt0, gnt1, rsp_valid, rsp_id, rsp_err, rsp_rdata,
                           eng_start, eng_abort, busy, state}), 32'd0);
      chk("rst.eng_cmd", eng_cmd, 32'd0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | rsp_valid | eng_abort | eng_start;
      end
      chk("rst.quiet", 32'(seen), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      do_txn("post_rst", 1'b0, 32'h33290001, 6, 1'b0, 8'h81, 2'b00, 8'h81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
